sram_strip_recorder: RTL and testbench

//  Captures a strip of ROWS x H_PIX camera pixels (two 16-bit SDRAM words each) into external SRAM.

---
 rtl/strip_rec_pkg.sv | 28 ++
 rtl/sram_port.sv | 60 ++++++
 rtl/sram_strip_recorder.sv | 207 ++++++++++++++++++++
 tb/tb_sram_strip_recorder.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_rec_pkg.sv
// strip_rec_pkg: shared types and helpers for the SRAM strip
// recorder (state encoding, strip size, pixel unpacking).
package strip_rec_pkg;

  localparam int H_PIX_DEF   = 800;
  localparam int ROWS_DEF    = 8;
  localparam int STRIP_WORDS = H_PIX_DEF * ROWS_DEF * 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC_WAIT,
    S_WR_LO,
    S_WR_HI,
    S_TURN,
    S_RD_LO,
    S_RD_HI,
    S_OUT
  } state_t;

  // lo: [14:10]=G[7:3] [9:2]=B ; hi: [14:12]=G[2:0] [9:2]=R
  function automatic logic [23:0] unpack_rgb(
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return {hi[9:2], lo[14:10], hi[14:12], lo[9:2]};
  endfunction

endpackage

// File: rtl/sram_port.sv
// sram_port: registered SRAM address and strobes, data bus
// tristate and read capture registers.
module sram_port #(
  parameter int          ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_clr,
  input  logic              addr_inc,
  input  logic              we_n_d,
  input  logic              oe_n_d,
  input  logic              dq_oe_d,
  input  logic [15:0]       wdata_d,
  input  logic              cap_lo,
  input  logic              cap_hi,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  inout  wire  [15:0]       sram_dq,
  output logic [15:0]       lo_r,
  output logic [15:0]       hi_r
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic        dq_oe;
  logic [15:0] wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      dq_oe     <= 1'b0;
      wdata     <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
    end else begin
      if (addr_clr) begin
        sram_addr <= BASE;
      end else if (addr_inc) begin
        sram_addr <= sram_addr + 1'b1;
      end
      sram_we_n <= we_n_d;
      sram_oe_n <= oe_n_d;
      dq_oe     <= dq_oe_d;
      wdata     <= wdata_d;
      if (cap_lo) begin
        lo_r <= sram_dq;
      end
      if (cap_hi) begin
        hi_r <= sram_dq;
      end
    end
  end

  assign sram_dq = dq_oe ? wdata : 16'hzzzz;

endmodule

// File: rtl/sram_strip_recorder.sv
// sram_strip_recorder: records one strip of camera pixels into
// SRAM, then replays it as RGB with valid/ready to the blur stage.
module sram_strip_recorder
  import strip_rec_pkg::*;
#(
  parameter int          H_PIX     = H_PIX_DEF,
  parameter int          ROWS      = ROWS_DEF,
  parameter int          ADDR_W    = 20,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pix_valid,
  input  logic [15:0]       i_sdram_data_1,
  input  logic [15:0]       i_sdram_data_2,
  output logic              o_ccd_pause,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n,
  output logic [23:0]       o_pix_rgb,
  output logic              o_pix_valid,
  input  logic              i_out_ready,
  output logic              o_row_end,
  output logic              o_done,
  output logic              o_busy
);

  localparam int NPIX  = H_PIX * ROWS;
  localparam int PIX_W = $clog2(NPIX);
  localparam int COL_W = $clog2(H_PIX);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t           state;
  logic [PIX_W-1:0] pix_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [15:0]      hi_w;
  logic [15:0]      lo_r;
  logic [15:0]      hi_r;
  logic             last_pix;

  logic        addr_clr;
  logic        addr_inc;
  logic        we_n_d;
  logic        oe_n_d;
  logic        dq_oe_d;
  logic [15:0] wdata_d;
  logic        cap_lo;
  logic        cap_hi;

  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  // Controls for the port registers take effect in the next state.
  always_comb begin
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    wdata_d  = hi_w;
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
    unique case (state)
      S_IDLE: addr_clr = i_start;
      S_REC_WAIT: begin
        if (i_pix_valid) begin
          we_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          wdata_d = i_sdram_data_1;
        end
      end
      S_WR_LO: begin
        addr_inc = 1'b1;
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
      end
      S_WR_HI: addr_inc = 1'b1;
      S_TURN: begin
        addr_clr = 1'b1;
        oe_n_d   = 1'b0;
      end
      S_RD_LO: begin
        cap_lo   = 1'b1;
        addr_inc = 1'b1;
        oe_n_d   = 1'b0;
      end
      S_RD_HI: begin
        cap_hi   = 1'b1;
        addr_inc = 1'b1;
      end
      S_OUT: oe_n_d = !(i_out_ready && !last_pix);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      pix_cnt     <= '0;
      col         <= '0;
      row         <= '0;
      hi_w        <= '0;
      o_ccd_pause <= 1'b0;
      o_pix_valid <= 1'b0;
      o_row_end   <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            pix_cnt <= '0;
            o_busy  <= 1'b1;
            state   <= S_REC_WAIT;
          end
        end
        S_REC_WAIT: begin
          if (i_pix_valid) begin
            hi_w        <= i_sdram_data_2;
            o_ccd_pause <= 1'b1;
            state       <= S_WR_LO;
          end
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: begin
          o_ccd_pause <= 1'b0;
          if (pix_cnt == PIX_LAST) begin
            pix_cnt <= '0;
            state   <= S_TURN;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
            state   <= S_REC_WAIT;
          end
        end
        S_TURN: begin
          col   <= '0;
          row   <= '0;
          state <= S_RD_LO;
        end
        S_RD_LO: state <= S_RD_HI;
        S_RD_HI: begin
          o_pix_valid <= 1'b1;
          o_row_end   <= (col == COL_LAST);
          state       <= S_OUT;
        end
        S_OUT: begin
          if (i_out_ready) begin
            o_pix_valid <= 1'b0;
            o_row_end   <= 1'b0;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_RD_LO;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sram_port #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_port (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .addr_clr (addr_clr),
    .addr_inc (addr_inc),
    .we_n_d   (we_n_d),
    .oe_n_d   (oe_n_d),
    .dq_oe_d  (dq_oe_d),
    .wdata_d  (wdata_d),
    .cap_lo   (cap_lo),
    .cap_hi   (cap_hi),
    .sram_addr(o_sram_addr),
    .sram_we_n(o_sram_we_n),
    .sram_oe_n(o_sram_oe_n),
    .sram_dq  (io_sram_dq),
    .lo_r     (lo_r),
    .hi_r     (hi_r)
  );

  assign o_pix_rgb   = unpack_rgb(lo_r, hi_r);
  assign o_sram_ce_n = ~i_rst_n;
  assign o_sram_ub_n = ~i_rst_n;
  assign o_sram_lb_n = ~i_rst_n;

endmodule

// File: tb/tb_sram_strip_recorder.sv
// tb_sram_strip_recorder: SRAM device model plus pixel
// scoreboard driving record and replay passes.
module tb_sram_strip_recorder;

  localparam int H_PIX  = 800;
  localparam int NPIX   = 6400;
  localparam int NWORDS = 12800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;
  logic        ready = 1'b0;
  logic        pause;
  logic [19:0] addr;
  wire  [15:0] sram_dq;
  logic        we_n;
  logic        oe_n;
  logic        ce_n;
  logic        ub_n;
  logic        lb_n;
  logic [23:0] rgb;
  logic        valid;
  logic        row_end;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:16383];
  logic [19:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [15:0] px_lo [0:NPIX-1];
  logic [15:0] px_hi [0:NPIX-1];

  always #10 clk = ~clk;

  sram_strip_recorder dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_pix_valid   (pix_valid),
    .i_sdram_data_1(d1),
    .i_sdram_data_2(d2),
    .o_ccd_pause   (pause),
    .o_sram_addr   (addr),
    .io_sram_dq    (sram_dq),
    .o_sram_we_n   (we_n),
    .o_sram_oe_n   (oe_n),
    .o_sram_ce_n   (ce_n),
    .o_sram_ub_n   (ub_n),
    .o_sram_lb_n   (lb_n),
    .o_pix_rgb     (rgb),
    .o_pix_valid   (valid),
    .i_out_ready   (ready),
    .o_row_end     (row_end),
    .o_done        (done),
    .o_busy        (busy)
  );

  // asynchronous SRAM device
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[addr[13:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst_n && !ce_n && !we_n) begin
      mem[addr[13:0]] <= sram_dq;
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(sram_dq);
    end
  end

  function automatic logic [23:0] exp_rgb(input logic [15:0] lo,
                                          input logic [15:0] hi);
    logic [7:0] r, g, b;
    r = hi[9:2];
    g = {lo[14:10], hi[14:12]};
    b = lo[9:2];
    return (24'(r) << 16) | (24'(g) << 8) | 24'(b);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (we_n !== 1'b1 || oe_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_strobes: we_n=%b oe_n=%b want 1 1", we_n, oe_n);
    end
    checks++;
    if (ce_n !== 1'b1 || ub_n !== 1'b1 || lb_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_ce: ce/ub/lb=%b%b%b want 111", ce_n, ub_n, lb_n);
    end
    checks++;
    if ({pause, valid, row_end, done, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b want 00000",
               {pause, valid, row_end, done, busy});
    end
    checks++;
    if (rgb !== 24'h0 || addr !== 20'h0) begin
      errors++;
      $display("FAIL rst_data: rgb=%h addr=%h want 0 0", rgb, addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ce_n !== 1'b0 || ub_n !== 1'b0 || lb_n !== 1'b0) begin
      errors++;
      $display("FAIL run_ce: ce/ub/lb=%b%b%b want 000", ce_n, ub_n, lb_n);
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    start = 1'b1;
    pix_valid = 1'b1;
    d1 = 16'h1234;
    d2 = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    while (we_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (we_n !== 1'b0 || addr !== 20'h0 || pause !== 1'b1) begin
      errors++;
      $display("FAIL wr_lo_reach: we_n=%b addr=%h pause=%b want 0 0 1",
               we_n, addr, pause);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (we_n !== 1'b1 || pause !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wr: we_n=%b pause=%b busy=%b want 1 0 0",
               we_n, pause, busy);
    end
    checks++;
    if (sram_dq === 16'h1234) begin
      errors++;
      $display("FAIL rst_mid_dq: dq=%h still driven, want released",
               sram_dq);
    end
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || we_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_abandon: busy=%b we_n=%b want 0 1", busy, we_n);
    end
  endtask

  task automatic test_record_const();
    int cyc = 0;
    int pbad = 0;
    int wbad = 0;
    int pcnt = 0;
    logic [15:0] w;
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    pix_valid = 1'b1;
    d1 = 16'h7FFC;
    d2 = 16'h73FC;
    @(negedge clk);
    start = 1'b0;
    while (oe_n && cyc < 25000) begin
      if (pause !== (cyc % 3 != 0)) pbad++;
      if (pause) pcnt++;
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    checks++;
    if (cyc != NPIX * 3 + 1) begin
      errors++;
      $display("FAIL rec_cycles: got %0d want %0d", cyc, NPIX * 3 + 1);
    end
    checks++;
    if (pbad != 0 || pcnt != NWORDS) begin
      errors++;
      $display("FAIL pause_2of3: bad=%0d high=%0d want 0 %0d",
               pbad, pcnt, NWORDS);
    end
    checks++;
    if (wr_addr_q.size() != NWORDS) begin
      errors++;
      $display("FAIL wr_count: got %0d want %0d",
               wr_addr_q.size(), NWORDS);
    end else begin
      for (int i = 0; i < NWORDS; i++) begin
        w = (i % 2 == 0) ? 16'h7FFC : 16'h73FC;
        if (wr_addr_q[i] !== 20'(i) || wr_data_q[i] !== w) wbad++;
      end
      checks++;
      if (wbad != 0) begin
        errors++;
        $display("FAIL wr_order: %0d bad words, want 0", wbad);
      end
    end
  endtask

  task automatic test_replay_const();
    int cyc = 0;
    int npix = 0;
    int last_v = -1;
    int vbad = 0;
    int rbad = 0;
    int gbad = 0;
    int dcnt = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    logic inj = 1'b0;
    ready = 1'b1;
    while (npix < NPIX && cyc < 22000) begin
      if (done) dcnt++;
      if (!we_n) gbad++;
      if (valid) begin
        if (rgb !== 24'hFFFFFF) vbad++;
        if (row_end !== (npix % H_PIX == H_PIX - 1)) rbad++;
        if (cyc - last_v != 3) gbad++;
        last_v = cyc;
        last_cyc = cyc;
        npix++;
      end else if (row_end) begin
        rbad++;
      end
      if (!inj && npix == 100 && !oe_n && addr[0]) begin
        start = 1'b1;
        inj = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (done) begin
        dcnt++;
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_with_done: busy=%b want 0", busy);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (npix != NPIX) begin
      errors++;
      $display("FAIL replay_count: got %0d want %0d", npix, NPIX);
    end
    checks++;
    if (vbad != 0) begin
      errors++;
      $display("FAIL replay_rgb: %0d pixels not FFFFFF", vbad);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL replay_row_end: %0d bad, want 0", rbad);
    end
    checks++;
    if (gbad != 0) begin
      errors++;
      $display("FAIL replay_cadence: %0d bad gaps, want 0", gbad);
    end
    checks++;
    if (dcnt != 1 || done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL done_pulse: count=%0d at %0d want 1 at %0d",
               dcnt, done_cyc, last_cyc + 1);
    end
    checks++;
    if (!inj || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_rd_hi: inj=%b busy=%b want 1 0", inj, busy);
    end
  endtask

  task automatic test_record_random();
    int cyc = 0;
    int nacc = 0;
    int wbad = 0;
    logic v;
    logic [15:0] w;
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    pix_valid = 1'($urandom_range(0, 1));
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    while (oe_n && cyc < 40000) begin
      v = (nacc < 1000) ? ($urandom_range(0, 3) == 0) : 1'b1;
      pix_valid = v;
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      if (v && busy && !pause && nacc < NPIX) begin
        px_lo[nacc] = d1;
        px_hi[nacc] = d2;
        nacc++;
      end
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    checks++;
    if (nacc != NPIX || oe_n !== 1'b0) begin
      errors++;
      $display("FAIL rnd_accept: got %0d oe_n=%b want %0d 0",
               nacc, oe_n, NPIX);
    end
    checks++;
    if (wr_addr_q.size() != NWORDS) begin
      errors++;
      $display("FAIL rnd_wr_count: got %0d want %0d",
               wr_addr_q.size(), NWORDS);
    end else begin
      for (int i = 0; i < NWORDS; i++) begin
        w = (i % 2 == 0) ? px_lo[i / 2] : px_hi[i / 2];
        if (wr_addr_q[i] !== 20'(i) || wr_data_q[i] !== w) wbad++;
      end
      checks++;
      if (wbad != 0) begin
        errors++;
        $display("FAIL rnd_wr_order: %0d bad words, want 0", wbad);
      end
    end
  endtask

  task automatic test_replay_stall();
    int cyc = 0;
    int npix = 0;
    int vbad = 0;
    int rbad = 0;
    int sbad = 0;
    logic stalled = 1'b0;
    logic r;
    logic [23:0] s_rgb;
    logic [19:0] s_addr;
    while (npix < 1000 && cyc < 8000) begin
      if (valid) begin
        if (rgb !== exp_rgb(px_lo[npix], px_hi[npix])) vbad++;
        if (row_end !== (npix % H_PIX == H_PIX - 1)) rbad++;
        if (npix == H_PIX - 1 && !stalled) begin
          stalled = 1'b1;
          s_rgb = exp_rgb(px_lo[npix], px_hi[npix]);
          s_addr = addr;
          ready = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cyc++;
            if (rgb !== s_rgb || valid !== 1'b1 ||
                row_end !== 1'b1 || addr !== s_addr) sbad++;
          end
        end
      end
      r = ($urandom_range(0, 3) != 0);
      ready = r;
      if (valid && r) npix++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (npix != 1000) begin
      errors++;
      $display("FAIL rnd_replay_count: got %0d want 1000", npix);
    end
    checks++;
    if (vbad != 0) begin
      errors++;
      $display("FAIL rnd_replay_rgb: %0d mismatched pixels", vbad);
    end
    checks++;
    if (rbad != 0) begin
      errors++;
      $display("FAIL rnd_row_end: %0d bad, want 0", rbad);
    end
    checks++;
    if (!stalled || sbad != 0) begin
      errors++;
      $display("FAIL stall_hold: stalled=%b unstable=%0d want 1 0",
               stalled, sbad);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (oe_n !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rd: oe_n=%b valid=%b busy=%b want 1 0 0",
               oe_n, valid, busy);
    end
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_record_const();
    test_replay_const();
    test_record_random();
    test_replay_stall();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
